// File: rtl/adrv9001_rx_packetizer.sv
// adrv9001_rx_packetizer
// Buffers one ADRV9001 receive channel's non-stallable IQ stream and emits
// fixed-length AXI-Stream packets with tlast. Space for a whole packet is
// reserved at its first sample, so a packet is either written completely or
// dropped completely and counted.
// Optional feature macro: ADRV9001_RX_PKT_TIMESTAMP_EN prefixes every accepted
// packet with a 32-bit sample-index header word.
//
// state  | meaning
// IDLE   | waiting for a packet start (valid sample with enable=1)
// ACCEPT | writing the remaining samples of a packet that has space reserved
// DROP   | discarding the remaining samples of a packet that did not fit
module adrv9001_rx_packetizer #(
  parameter int FIFO_DEPTH = 1024,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                        s_axis_aclk,
  input  logic                        s_axis_rstn,
  input  logic [31:0]                 s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic [31:0]                 m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  output logic                        m_axis_tlast,
  input  logic                        enable,
  input  logic [LEN_WIDTH-1:0]        pkt_len,
  output logic [LEN_WIDTH-1:0]        pkt_count,
  output logic [LEN_WIDTH-1:0]        drop_count,
  output logic                        cfg_err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = ((LEN_WIDTH > PW) ? LEN_WIDTH : PW) + 2;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, DROP = 2'd2} state_t;

  state_t               state_q;
  logic [LEN_WIDTH-1:0] len_q, cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] pkt_count_q, drop_count_q;
  logic                 cfg_err_q;
  logic [1:0]           wr_n_q;
  logic [32:0]          wr0_q;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
  logic [32:0]          wr1_q;
  logic [31:0]          ts_q;
  logic [PW-1:0]        wptr1;
`endif
  logic [32:0]          mem_q [FIFO_DEPTH];
  logic [PW-1:0]        wptr_q, rptr_q, level_q;
  logic                 out_valid_q;
  logic [32:0]          out_word_q;

  logic                 pkt_start, len_bad, fits, seg_end, rd_fire, mem_empty;
  logic [1:0]           acc_n;
  logic [CW-1:0]        need, free;

  function automatic logic [LEN_WIDTH-1:0] sat_inc(input logic [LEN_WIDTH-1:0] v);
    return (v == '1) ? v : v + LEN_WIDTH'(1);
  endfunction

  // Packet-start qualification, space reservation and words accepted this cycle.
  always_comb begin
    pkt_start = (state_q == IDLE) && s_axis_tvalid && enable;
    need      = CW'(pkt_len) + CW'(HDR);
    free      = CW'(FIFO_DEPTH) - CW'(level_q);
    len_bad   = (pkt_len == '0) || (need > CW'(FIFO_DEPTH));
    fits      = (free >= need);
    cnt_d     = cnt_q + LEN_WIDTH'(1);
    seg_end   = (cnt_d == len_q);
    acc_n     = 2'd0;
    if (pkt_start && !len_bad && fits) acc_n = 2'(1 + HDR);
    else if ((state_q == ACCEPT) && s_axis_tvalid) acc_n = 2'd1;
  end

  // Write FSM: packet framing, counters and the staged write word(s).
  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      state_q      <= IDLE;
      len_q        <= '0;
      cnt_q        <= '0;
      pkt_count_q  <= '0;
      drop_count_q <= '0;
      cfg_err_q    <= 1'b0;
      wr_n_q       <= 2'd0;
      wr0_q        <= '0;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
      wr1_q        <= '0;
      ts_q         <= '0;
`endif
    end else begin
      wr_n_q <= acc_n;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
      if (s_axis_tvalid) ts_q <= ts_q + 32'd1;
`endif
      case (state_q)
        IDLE: begin
          if (pkt_start) begin
            len_q <= pkt_len;
            cnt_q <= LEN_WIDTH'(1);
            if (len_bad) begin
              cfg_err_q <= 1'b1;
            end else begin
              cfg_err_q <= 1'b0;
              if (fits) begin
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
                wr0_q <= {1'b0, ts_q};
                wr1_q <= {(pkt_len == LEN_WIDTH'(1)), s_axis_tdata};
`else
                wr0_q <= {(pkt_len == LEN_WIDTH'(1)), s_axis_tdata};
`endif
                if (pkt_len == LEN_WIDTH'(1)) pkt_count_q <= sat_inc(pkt_count_q);
                else state_q <= ACCEPT;
              end else begin
                if (pkt_len == LEN_WIDTH'(1)) drop_count_q <= sat_inc(drop_count_q);
                else state_q <= DROP;
              end
            end
          end
        end
        ACCEPT: begin
          if (s_axis_tvalid) begin
            wr0_q <= {seg_end, s_axis_tdata};
            cnt_q <= cnt_d;
            if (seg_end) begin
              pkt_count_q <= sat_inc(pkt_count_q);
              state_q     <= IDLE;
            end
          end
        end
        DROP: begin
          if (s_axis_tvalid) begin
            cnt_q <= cnt_d;
            if (seg_end) begin
              drop_count_q <= sat_inc(drop_count_q);
              state_q      <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
  assign wptr1 = wptr_q + PW'(1);
`endif

  // Storage array; left unreset so it can map onto plain RAM.
  always_ff @(posedge s_axis_aclk) begin
    if (wr_n_q != 2'd0) mem_q[wptr_q[AW-1:0]] <= wr0_q;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
    if (wr_n_q == 2'd2) mem_q[wptr1[AW-1:0]] <= wr1_q;
`endif
  end

  assign mem_empty = (wptr_q == rptr_q);
  assign rd_fire   = out_valid_q && m_axis_tready;

  // Pointers, occupancy and the registered head-word output stage.
  always_ff @(posedge s_axis_aclk or negedge s_axis_rstn) begin
    if (!s_axis_rstn) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      out_valid_q <= 1'b0;
      out_word_q  <= '0;
    end else begin
      wptr_q  <= wptr_q + PW'(wr_n_q);
      level_q <= level_q + PW'(acc_n) - PW'(rd_fire);
      if ((!out_valid_q || m_axis_tready) && !mem_empty) begin
        out_word_q  <= mem_q[rptr_q[AW-1:0]];
        out_valid_q <= 1'b1;
        rptr_q      <= rptr_q + PW'(1);
      end else if (m_axis_tready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_valid_q;
  assign m_axis_tdata  = out_word_q[31:0];
  assign m_axis_tlast  = out_valid_q & out_word_q[32];
  assign pkt_count     = pkt_count_q;
  assign drop_count    = drop_count_q;
  assign cfg_err       = cfg_err_q;
  assign fifo_level    = level_q;

endmodule

// File: tb/tb_adrv9001_rx_packetizer.sv
// Self-checking bench for adrv9001_rx_packetizer: randomized and directed
// stimulus, a packet-level reference model feeding an expected-word queue,
// and an independent output monitor that pops and compares.
module tb_adrv9001_rx_packetizer;
  localparam int DEPTH = 16;
`ifdef ADRV9001_RX_PKT_TIMESTAMP_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] s_axis_tdata;
  logic        s_axis_tvalid;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        enable;
  logic [15:0] pkt_len;
  logic [15:0] pkt_count;
  logic [15:0] drop_count;
  logic        cfg_err;
  logic [4:0]  fifo_level;

  adrv9001_rx_packetizer #(.FIFO_DEPTH(DEPTH), .LEN_WIDTH(16)) dut (
    .s_axis_aclk(clk), .s_axis_rstn(rstn),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .enable(enable), .pkt_len(pkt_len), .pkt_count(pkt_count),
    .drop_count(drop_count), .cfg_err(cfg_err), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  // Reference model state (packet-level view)
  logic [32:0] exp_q[$];
  int          m_rem = 0;
  bit          m_acc = 0;
  int          m_pkts = 0;
  int          m_drops = 0;
  bit          m_cfg_err = 0;
  int unsigned m_ts = 0;

  int  n_words = 0;
  bit  seen_valid = 0;
  int  first_valid_cyc = -100;
  int  wr_edge = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_rem = 0; m_acc = 0; m_pkts = 0; m_drops = 0; m_cfg_err = 0; m_ts = 0;
  endtask

  // One valid sample as seen by the model; level is what is still queued.
  task automatic model_sample(input logic [31:0] d, input bit en, input int len);
    if (m_rem == 0 && en) begin
      if (len == 0 || len + HDR > DEPTH) begin
        m_cfg_err = 1;
      end else begin
        m_cfg_err = 0;
        m_acc = ((DEPTH - exp_q.size()) >= len + HDR);
        if (m_acc && HDR != 0) exp_q.push_back({1'b0, m_ts});
        m_rem = len;
      end
    end
    if (m_rem > 0) begin
      m_rem--;
      if (m_acc) exp_q.push_back({(m_rem == 0), d});
      if (m_rem == 0) begin
        if (m_acc) m_pkts++;
        else m_drops++;
      end
    end
    m_ts++;
  endtask

  task automatic drive(input bit v, input logic [31:0] d, input bit en, input int len, input bit rdy);
    @(posedge clk); #1;
    s_axis_tvalid = v;
    s_axis_tdata  = d;
    enable        = en;
    pkt_len       = 16'(len);
    m_axis_tready = rdy;
    if (v) model_sample(d, en, len);
  endtask

  task automatic drain(input int len);
    int n = 0;
    while (m_rem != 0) drive(1'b1, $urandom, 1'b0, len, 1'b1);
    while ((exp_q.size() != 0 || m_axis_tvalid) && n < 300) begin
      drive(1'b0, 32'h0, 1'b0, len, 1'b1);
      n++;
    end
    repeat (4) drive(1'b0, 32'h0, 1'b0, len, 1'b1);
    chk("drain_left", exp_q.size(), 0);
    @(negedge clk);
    chk("drain_level", fifo_level, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0;
    s_axis_tvalid = 0; enable = 0; m_axis_tready = 0;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
  endtask

  // Output monitor: checks hold-while-stalled and pops expected words on transfer.
  bit          hold_v = 0;
  logic [32:0] hold_w;
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn) begin
        hold_v = 0;
      end else begin
        if (hold_v) chk("out_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, hold_w});
        if (m_axis_tvalid && !seen_valid) begin
          seen_valid = 1;
          first_valid_cyc = cyc;
        end
        if (m_axis_tvalid && m_axis_tready) begin
          n_words++;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word actual=%0h expected=none", {m_axis_tlast, m_axis_tdata});
          end else begin
            chk("out_word", {m_axis_tlast, m_axis_tdata}, exp_q.pop_front());
          end
        end
        hold_v = m_axis_tvalid && !m_axis_tready;
        hold_w = {m_axis_tlast, m_axis_tdata};
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, w0;
    rstn = 1'b0;
    s_axis_tvalid = 0; s_axis_tdata = 0; enable = 0; pkt_len = 0; m_axis_tready = 0;
    model_clear();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_pkt_count", pkt_count, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_cfg_err", cfg_err, 0);

    // Two back-to-back 4-sample packets, latency from first write.
    seen_valid = 0;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 32'h00010001 * i, 1'b1, 4, 1'b1);
      if (i == 1) wr_edge = cyc + 1;
    end
    drain(4);
    chk("t1_latency", first_valid_cyc - wr_edge, 2);
    chk("t1_pkt_count", pkt_count, 2);
    chk("t1_pkt_model", pkt_count, m_pkts);

    // Fill with tready low, third packet dropped, then drain.
    do_reset();
    for (int i = 0; i < 24; i++) drive(1'b1, $urandom, 1'b1, 8, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 8, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 8, 1'b0);
    @(negedge clk);
    chk("t2_level", fifo_level, exp_q.size());
    chk("t2_drop_count", drop_count, m_drops);
    drain(8);
    chk("t2_pkt_count", pkt_count, m_pkts);

    // enable dropped mid-packet is ignored until the packet ends.
    drive(1'b1, 32'hA0000001, 1'b1, 4, 1'b1);
    drive(1'b1, 32'hA0000002, 1'b1, 4, 1'b1);
    for (int i = 3; i <= 6; i++) drive(1'b1, 32'hA0000000 + i, 1'b0, 4, 1'b1);
    drain(4);
    chk("t3_pkt_count", pkt_count, m_pkts);

    // Illegal lengths, then recovery.
    drive(1'b1, 32'hBEEF0000, 1'b1, 0, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 0, 1'b1);
    @(negedge clk);
    chk("t4_cfg_err_len0", cfg_err, m_cfg_err);
    chk("t4_level_len0", fifo_level, 0);
    drive(1'b1, 32'hBEEF0001, 1'b1, DEPTH + 1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, DEPTH + 1, 1'b1);
    @(negedge clk);
    chk("t4_cfg_err_big", cfg_err, m_cfg_err);
    chk("t4_level_big", fifo_level, 0);
    drive(1'b1, 32'hBEEF0002, 1'b1, 2, 1'b1);
    drive(1'b1, 32'hBEEF0003, 1'b1, 2, 1'b1);
    drain(2);
    chk("t4_cfg_err_ok", cfg_err, m_cfg_err);
    chk("t4_pkt_count", pkt_count, m_pkts);

    // Random drain with continuous then sparse samples.
    p0 = pkt_count;
    w0 = n_words;
    for (int i = 0; i < 300; i++)
      drive(1'b1, $urandom, 1'b1, 5, 1'($urandom_range(0, 1)));
    for (int i = 0; i < 300; i++)
      drive(1'($urandom_range(0, 9) < 3), $urandom, 1'b1, 5, 1'($urandom_range(0, 1)));
    drain(5);
    chk("t5_pkt_count", pkt_count, m_pkts);
    chk("t5_drop_count", drop_count, m_drops);
    chk("t5_words", n_words - w0, (5 + HDR) * (pkt_count - p0));

    // Reset in the middle of an accepted packet.
    do_reset();
    drive(1'b1, 32'hC0000001, 1'b1, 4, 1'b0);
    drive(1'b1, 32'hC0000002, 1'b1, 4, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 4, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 4, 1'b0);
    @(negedge clk);
    chk("t6_pre_tvalid", m_axis_tvalid, 1);
    @(posedge clk); #1;
    rstn = 1'b0;
    #1;
    chk("t6_rst_tvalid", m_axis_tvalid, 0);
    chk("t6_rst_tlast", m_axis_tlast, 0);
    chk("t6_rst_tdata", m_axis_tdata, 0);
    chk("t6_rst_level", fifo_level, 0);
    chk("t6_rst_counts", {pkt_count, drop_count, 15'd0, cfg_err}, 0);
    model_clear();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int i = 1; i <= 4; i++) drive(1'b1, 32'hD0000000 + i, 1'b1, 4, 1'b1);
    drain(4);
    chk("t6_pkt_count", pkt_count, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
